// File: rtl/usb3_pkg.sv
// Shared definitions for the USB3 slave-FIFO read path: state codes seen by the
// parameter cache and the default frame terminator.
package usb3_pkg;

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] WAIT  = 4'd3;
    localparam logic [3:0] OE    = 4'd5;
    localparam logic [3:0] READ  = 4'd6;
    localparam logic [3:0] DRAIN = 4'd7;
    localparam logic [3:0] CHECK = 4'd8;
    localparam logic [3:0] ABORT = 4'd9;

    localparam logic [31:0] END_WORD_DEF = 32'hFF00AAAA;

    typedef enum logic [3:0] {
        StIdle  = IDLE,
        StWait  = WAIT,
        StOe    = OE,
        StRead  = READ,
        StDrain = DRAIN,
        StCheck = CHECK,
        StAbort = ABORT
    } rd_state_e;

endpackage

// File: rtl/usb3_rd_ctrl_if.sv
// FX3 slave-FIFO pins plus the cache write port of the read controller.
interface usb3_rd_ctrl_if;

    logic        usb3_flaga;
    logic [31:0] usb3_data;
    logic        usb3_slcs_n;
    logic        usb3_sloe_n;
    logic        usb3_slrd_n;
    logic [3:0]  usb_rd_state;
    logic [31:0] wr_data;
    logic [7:0]  wr_addr;
    logic        wr_en;
    logic        frame_done;
    logic        frame_err;

    modport master (
        input  usb3_flaga, usb3_data,
        output usb3_slcs_n, usb3_sloe_n, usb3_slrd_n, usb_rd_state,
        output wr_data, wr_addr, wr_en, frame_done, frame_err
    );

    modport slave (
        output usb3_flaga, usb3_data,
        input  usb3_slcs_n, usb3_sloe_n, usb3_slrd_n, usb_rd_state,
        input  wr_data, wr_addr, wr_en, frame_done, frame_err
    );

endinterface

// File: rtl/usb3_rd_align.sv
// Delays each issued read strobe by the FX3 read latency and captures the bus
// word that belongs to it, producing one write strobe per word.
module usb3_rd_align #(
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_strobe,
    input  logic [31:0] usb3_data,
    output logic [31:0] wr_data,
    output logic        wr_en
);

    logic [RD_LATENCY-1:0] vld_q;
    logic [31:0]           wr_data_q;
    logic                  wr_en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            vld_q[0] <= rd_strobe;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            // Tail bit marks the cycle the FX3 word for that strobe is on the bus
            wr_en_q <= vld_q[RD_LATENCY-1];
            if (vld_q[RD_LATENCY-1]) begin
                wr_data_q <= usb3_data;
            end
        end
    end

    assign wr_data = wr_data_q;
    assign wr_en   = wr_en_q;

endmodule

// File: rtl/usb3_rd_ctrl.sv
// FX3 slave-FIFO burst reader: qualifies FLAGA, issues a read burst, drains the
// latency pipeline and validates the frame terminator.
module usb3_rd_ctrl
    import usb3_pkg::*;
#(
    parameter int unsigned BURST_LEN  = 256,
    parameter int unsigned RD_LATENCY = 2,
    parameter logic [31:0] END_WORD   = END_WORD_DEF,
    parameter int unsigned FLAG_WAIT  = 2
) (
    input logic            clk,
    input logic            rst,
    usb3_rd_ctrl_if.master bus
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;
    localparam int unsigned LAT_W = $clog2(RD_LATENCY) + 1;
    localparam int unsigned FW_W  = $clog2(FLAG_WAIT) + 1;

    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(BURST_LEN - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY - 1);
    localparam logic [FW_W-1:0]  FW_LAST  = FW_W'(FLAG_WAIT - 1);

    rd_state_e        state_q, state_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [FW_W-1:0]  flag_cnt_q, flag_cnt_d;
    logic [7:0]       wr_addr_q;

    logic        rd_strobe;
    logic        slcs_n;
    logic        sloe_n;
    logic        frame_done;
    logic        frame_err;
    logic [31:0] wr_data;
    logic        wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rd_cnt_q   <= '0;
            lat_cnt_q  <= '0;
            flag_cnt_q <= '0;
            wr_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            flag_cnt_q <= flag_cnt_d;
            if (state_q == StOe) begin
                wr_addr_q <= '0;
            end else if (wr_en) begin
                wr_addr_q <= wr_addr_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        flag_cnt_d = flag_cnt_q;
        slcs_n     = 1'b1;
        sloe_n     = 1'b1;
        rd_strobe  = 1'b0;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // The IDLE sample counts as the first qualifying FLAGA cycle
                if (bus.usb3_flaga) begin
                    state_d    = StWait;
                    flag_cnt_d = FW_W'(1);
                end
            end
            StWait: begin
                if (!bus.usb3_flaga) begin
                    state_d = StIdle;
                end else if (flag_cnt_q >= FW_LAST) begin
                    state_d = StOe;
                end else begin
                    flag_cnt_d = flag_cnt_q + 1'b1;
                end
            end
            StOe: begin
                slcs_n   = 1'b0;
                sloe_n   = 1'b0;
                rd_cnt_d = '0;
                state_d  = StRead;
            end
            StRead: begin
                slcs_n    = 1'b0;
                sloe_n    = 1'b0;
                rd_strobe = 1'b1;
                rd_cnt_d  = rd_cnt_q + 1'b1;
                lat_cnt_d = '0;
                // Final strobe wins over a simultaneous FLAGA drop
                if (rd_cnt_q == RD_LAST) begin
                    state_d = StDrain;
                end else if (!bus.usb3_flaga) begin
                    state_d = StAbort;
                end
            end
            StDrain, StAbort: begin
                slcs_n    = 1'b0;
                sloe_n    = 1'b0;
                lat_cnt_d = lat_cnt_q + 1'b1;
                if (lat_cnt_q == LAT_LAST) begin
                    if (state_q == StDrain) begin
                        state_d = StCheck;
                    end else begin
                        state_d   = StIdle;
                        frame_err = 1'b1;
                    end
                end
            end
            StCheck: begin
                if (wr_data == END_WORD) begin
                    frame_done = 1'b1;
                end else begin
                    frame_err = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    usb3_rd_align #(
        .RD_LATENCY (RD_LATENCY)
    ) u_align (
        .clk       (clk),
        .rst       (rst),
        .rd_strobe (rd_strobe),
        .usb3_data (bus.usb3_data),
        .wr_data   (wr_data),
        .wr_en     (wr_en)
    );

    assign bus.usb3_slcs_n  = slcs_n;
    assign bus.usb3_sloe_n  = sloe_n;
    assign bus.usb3_slrd_n  = ~rd_strobe;
    assign bus.usb_rd_state = state_q;
    assign bus.wr_data      = wr_data;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_en        = wr_en;
    assign bus.frame_done   = frame_done;
    assign bus.frame_err    = frame_err;

endmodule

// File: tb/tb_usb3_rd_ctrl.sv
// Bench for usb3_rd_ctrl: FX3 FIFO model with read latency, write scoreboard,
// and directed frame / abort / reset / back-to-back scenarios.
module tb_usb3_rd_ctrl;
    import usb3_pkg::*;

    localparam int unsigned BURST_LEN  = 256;
    localparam int unsigned RD_LATENCY = 2;
    localparam int unsigned FLAG_WAIT  = 2;
    localparam logic [31:0] END_WORD   = 32'hFF00AAAA;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    usb3_rd_ctrl_if bus ();

    usb3_rd_ctrl #(
        .BURST_LEN  (BURST_LEN),
        .RD_LATENCY (RD_LATENCY),
        .END_WORD   (END_WORD),
        .FLAG_WAIT  (FLAG_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] frame_mem [BURST_LEN];
    logic [31:0] d_pipe [RD_LATENCY];
    int          rd_idx = 0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          n_wr, n_done, n_err, n_strobe, first_rd, first_wr, last_wr;

    assign bus.usb3_data = d_pipe[RD_LATENCY-1];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // FX3 model: a word per strobe, visible RD_LATENCY edges after the strobe edge
    always @(posedge clk) begin
        if (bus.usb3_slrd_n == 1'b0 && rd_idx < BURST_LEN) begin
            d_pipe[0] <= frame_mem[rd_idx];
            exp_q.push_back('{addr: 8'(rd_idx), data: frame_mem[rd_idx]});
            rd_idx = rd_idx + 1;
        end else begin
            d_pipe[0] <= 32'hDEAD_BEEF;
        end
        for (int i = 1; i < RD_LATENCY; i++) d_pipe[i] <= d_pipe[i-1];
        if (bus.usb_rd_state == OE) rd_idx = 0;
    end

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (!bus.usb3_slrd_n) begin
            n_strobe++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (bus.wr_en) begin
            n_wr++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("wr_addr", 64'(bus.wr_addr), 64'(mon_e.addr));
                check_eq("wr_data", 64'(bus.wr_data), 64'(mon_e.data));
            end
        end
        if (bus.frame_done) n_done++;
        if (bus.frame_err) n_err++;
        if (bus.frame_done || bus.frame_err)
            check_eq("done_err_excl", 64'(bus.frame_done & bus.frame_err), 64'd0);
    end

    task automatic clr_stats();
        n_wr = 0; n_done = 0; n_err = 0; n_strobe = 0;
        first_rd = -1; first_wr = -1; last_wr = -1;
    endtask

    task automatic wait_state(input string tag, input logic [3:0] st, input int budget);
        int n = 0;
        while (bus.usb_rd_state != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 64'(bus.usb_rd_state), 64'(st));
    endtask

    task automatic wait_strobes(input int cnt);
        int n = 0;
        while (n_strobe < cnt && n < 600) begin
            @(negedge clk);
            n++;
        end
        check_eq("strobe_cnt", 64'(n_strobe), 64'(cnt));
    endtask

    task automatic run_frame();
        bus.usb3_flaga = 1'b1;
        wait_state("to_drain", DRAIN, 600);
        bus.usb3_flaga = 1'b0;
        wait_state("to_idle", IDLE, 20);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_state"}, 64'(bus.usb_rd_state), 64'(IDLE));
        check_eq({tag, "_slcs"}, 64'(bus.usb3_slcs_n), 64'd1);
        check_eq({tag, "_sloe"}, 64'(bus.usb3_sloe_n), 64'd1);
        check_eq({tag, "_slrd"}, 64'(bus.usb3_slrd_n), 64'd1);
        check_eq({tag, "_wr_en"}, 64'(bus.wr_en), 64'd0);
    endtask

    initial begin
        int n;
        clr_stats();
        for (int i = 0; i < BURST_LEN; i++) frame_mem[i] = 32'(i);
        frame_mem[BURST_LEN-1] = END_WORD;
        bus.usb3_flaga = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        check_idle_outputs("rst");
        check_eq("rst_done", 64'(bus.frame_done), 64'd0);
        check_eq("rst_err", 64'(bus.frame_err), 64'd0);
        check_eq("rst_addr", 64'(bus.wr_addr), 64'd0);
        check_eq("rst_data", 64'(bus.wr_data), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full frame with correct terminator
        clr_stats();
        run_frame();
        check_eq("full_nwr", 64'(n_wr), 64'(BURST_LEN));
        check_eq("full_done", 64'(n_done), 64'd1);
        check_eq("full_err", 64'(n_err), 64'd0);
        check_eq("full_lat", 64'(first_wr - first_rd), 64'(RD_LATENCY + 1));
        check_eq("full_consec", 64'(last_wr - first_wr), 64'(BURST_LEN - 1));
        check_eq("full_sb_left", 64'(exp_q.size()), 64'd0);

        // Wrong terminator
        frame_mem[BURST_LEN-1] = 32'hFF00AAAB;
        clr_stats();
        run_frame();
        check_eq("badterm_nwr", 64'(n_wr), 64'(BURST_LEN));
        check_eq("badterm_err", 64'(n_err), 64'd1);
        check_eq("badterm_done", 64'(n_done), 64'd0);
        frame_mem[BURST_LEN-1] = END_WORD;

        // Single-cycle FLAGA glitch
        clr_stats();
        bus.usb3_flaga = 1'b1;
        @(negedge clk);
        bus.usb3_flaga = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check_eq("glitch_slrd", 64'(bus.usb3_slrd_n), 64'd1);
            check_eq("glitch_state",
                     64'(bus.usb_rd_state == IDLE || bus.usb_rd_state == WAIT), 64'd1);
        end
        check_eq("glitch_strobes", 64'(n_strobe), 64'd0);

        // FLAGA lost after 100 strobes
        clr_stats();
        bus.usb3_flaga = 1'b1;
        wait_strobes(100);
        bus.usb3_flaga = 1'b0;
        @(negedge clk);
        check_eq("abort_slrd", 64'(bus.usb3_slrd_n), 64'd1);
        check_eq("abort_state", 64'(bus.usb_rd_state), 64'(ABORT));
        wait_state("abort_idle", IDLE, 20);
        repeat (4) @(negedge clk);
        check_eq("abort_nwr", 64'(n_wr), 64'd100);
        check_eq("abort_err", 64'(n_err), 64'd1);
        check_eq("abort_done", 64'(n_done), 64'd0);
        check_eq("abort_sb_left", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a burst, then a clean frame
        clr_stats();
        bus.usb3_flaga = 1'b1;
        wait_strobes(50);
        rst = 1'b1;
        bus.usb3_flaga = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        clr_stats();
        run_frame();
        check_eq("postrst_nwr", 64'(n_wr), 64'(BURST_LEN));
        check_eq("postrst_done", 64'(n_done), 64'd1);
        check_eq("postrst_sb_left", 64'(exp_q.size()), 64'd0);

        // Back-to-back frames with FLAGA held high
        clr_stats();
        bus.usb3_flaga = 1'b1;
        wait_state("b2b_check", CHECK, 600);
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (bus.usb_rd_state == OE) break;
        end
        check_eq("b2b_gap", 64'(n), 64'(FLAG_WAIT + 1));
        wait_state("b2b_drain", DRAIN, 600);
        bus.usb3_flaga = 1'b0;
        wait_state("b2b_idle", IDLE, 20);
        repeat (4) @(negedge clk);
        check_eq("b2b_done", 64'(n_done), 64'd2);
        check_eq("b2b_err", 64'(n_err), 64'd0);
        check_eq("b2b_nwr", 64'(n_wr), 64'(2 * BURST_LEN));
        check_eq("b2b_sb_left", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
